am_psum_accum: RTL and testbench

- Downstream consumer of the 8x8 unsigned approximate multiplier used in the VGG16 datapath.
- Takes the 16-bit product stream over a valid/ready handshake and accumulates a configurable number of products into one partial sum, i.e. one output pixel's dot product.
- Presents the sum with a sticky overflow flag on a valid/ready output port.
- Sits between the multiplier array and the requantise/activation stage.

---
 rtl/am_accum_pkg.sv | 26 ++
 rtl/am_sat_add.sv | 27 ++
 rtl/am_psum_accum.sv | 84 ++++++++
 tb/tb_am_psum_accum.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/am_accum_pkg.sv
// Shared types, default widths and elaboration helpers for the partial-sum
// accumulator. Optional build macro used by this slice: AM_PSUM_SATURATE_EN.
package am_accum_pkg;

  localparam int unsigned PROD_W_DEF = 16;
  localparam int unsigned ACC_W_DEF  = 24;
  localparam int unsigned LEN_W_DEF  = 12;

  // Legacy encodings kept so existing waveform decoders still line up.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ACCUM = ST_ACCUM,
    DONE  = ST_DONE
  } state_t;

  // A product can only be zero-extended into the accumulator if it fits.
  function automatic bit zext_width_ok(input int unsigned prod_w,
                                       input int unsigned acc_w);
    return acc_w >= prod_w;
  endfunction

endpackage

// File: rtl/am_sat_add.sv
// Combinational accumulator adder producing the ACC_W sum and its carry out.
// With AM_PSUM_SATURATE_EN defined the sum clamps to all-ones on carry;
// otherwise it wraps modulo 2^ACC_W.
module am_sat_add #(
  parameter int unsigned ACC_W = 24
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] prod,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] wide;

  // Full-width add; a clamped accumulator stays clamped because any further
  // non-zero addend carries again and a zero addend leaves it unchanged.
  always_comb begin
    wide  = {1'b0, acc} + {1'b0, prod};
    carry = wide[ACC_W];
`ifdef AM_PSUM_SATURATE_EN
    sum   = carry ? '1 : wide[ACC_W-1:0];
`else
    sum   = wide[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/am_psum_accum.sv
// Partial-sum accumulator: sums cfg_len+1 products from the multiplier stream
// into one result presented with a sticky overflow flag over valid/ready.
// Build option: AM_PSUM_SATURATE_EN (clamp instead of wrap, see am_sat_add).
module am_psum_accum
  import am_accum_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam bit WIDTH_OK = zext_width_ok(PROD_W, ACC_W);

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic              ovf;
  logic [LEN_W-1:0]  cnt;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  add_sum;
  logic              add_carry;
  logic              beat;
  logic              taken;
  logic              load;

  assign prod_ext = WIDTH_OK ? ACC_W'(in_prod) : '0;

  am_sat_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc   (acc),
    .prod  (prod_ext),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Handshake decode; in DONE a new window may start only as the result leaves.
  always_comb begin
    out_valid = (state == DONE);
    in_ready  = (state == DONE) ? out_ready : 1'b1;
    beat      = in_valid && in_ready;
    taken     = out_valid && out_ready;
    load      = beat && ((state == IDLE) || (state == DONE));
  end

  assign out_sum = acc;
  assign out_ovf = ovf;

  // Window FSM; a beat in DONE implies the result is taken, so loading from
  // IDLE and DONE shares one branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= prod_ext;
      ovf   <= 1'b0;
      cnt   <= cfg_len;
      state <= (cfg_len == '0) ? DONE : ACCUM;
    end else if ((state == ACCUM) && beat) begin
      acc   <= add_sum;
      ovf   <= ovf | add_carry;
      cnt   <= cnt - LEN_W'(1);
      if (cnt == LEN_W'(1)) begin
        state <= DONE;
      end
    end else if (taken) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_am_psum_accum.sv
// Self-checking bench for am_psum_accum: vector table, directed corner
// sequences and a randomized stream against a window-level reference model.
module tb_am_psum_accum;

  localparam longint ACC_MAX = 64'd16777215;

  logic        clk;
  logic        rst_n;
  logic [11:0] cfg_len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_prod;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_sum;
  logic        out_ovf;

  int n_cmp = 0;
  int n_err = 0;

  am_psum_accum #(
    .PROD_W (16),
    .ACC_W  (24),
    .LEN_W  (12)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    int unsigned prod;
    int unsigned len;
    bit          ordy;
    bit          e_ir;
    bit          e_ov;
    int unsigned e_sum;
    bit          e_ovf;
  } vec_t;

  typedef struct {
    longint sum;
    bit     ovf;
  } res_t;

  vec_t vecs[10];
  res_t q[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input int unsigned p, input int unsigned l,
                       input bit r);
    in_valid  = v;
    in_prod   = p[15:0];
    cfg_len   = l[11:0];
    out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input bit ir, input bit ov,
                         input longint s, input bit o);
    #2;
    chk({nm, ".in_ready"}, longint'(in_ready), longint'(ir));
    chk({nm, ".out_valid"}, longint'(out_valid), longint'(ov));
    if (ov) begin
      chk({nm, ".out_sum"}, longint'(out_sum), s);
      chk({nm, ".out_ovf"}, longint'(out_ovf), longint'(o));
    end
  endtask

  initial begin
    longint exp_ovf_sum;
    bit     in_win;
    int     rem;
    longint run;

    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", longint'(out_valid), 0);
    chk("reset.out_sum", longint'(out_sum), 0);
    chk("reset.out_ovf", longint'(out_ovf), 0);
    chk("reset.in_ready", longint'(in_ready), 1);
    #2 rst_n = 1'b1;
    tick();

    // Back-to-back window of four, then three single-product windows.
    vecs[0] = '{1, 100,   3, 1, 1, 0, 0,     0};
    vecs[1] = '{1, 200,   3, 1, 1, 0, 0,     0};
    vecs[2] = '{1, 300,   3, 1, 1, 0, 0,     0};
    vecs[3] = '{1, 400,   3, 1, 1, 0, 0,     0};
    vecs[4] = '{0, 0,     0, 1, 1, 1, 1000,  0};
    vecs[5] = '{1, 65025, 0, 1, 1, 0, 0,     0};
    vecs[6] = '{1, 7,     0, 1, 1, 1, 65025, 0};
    vecs[7] = '{1, 9,     0, 1, 1, 1, 7,     0};
    vecs[8] = '{0, 0,     0, 1, 1, 1, 9,     0};
    vecs[9] = '{0, 0,     0, 1, 1, 0, 0,     0};
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].v, vecs[i].prod, vecs[i].len, vecs[i].ordy);
      chk_out($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov,
              longint'(vecs[i].e_sum), vecs[i].e_ovf);
      tick();
    end

    // Output backpressure, then a new window started as the result leaves.
    drive(1, 1, 1, 1); tick();
    drive(1, 2, 1, 1); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 50, 0, 0);
      chk_out("bp.hold", 0, 1, 3, 0);
      tick();
    end
    drive(1, 4, 1, 1);
    chk_out("bp.release", 1, 1, 3, 0);
    tick();
    drive(1, 5, 0, 0);
    chk_out("bp.second", 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1);
    chk_out("bp.result2", 1, 1, 9, 0);
    tick();

    // 300 products of 65025 overflow a 24-bit accumulator.
    for (int i = 0; i < 300; i++) begin
      drive(1, 65025, 299, 1);
      tick();
    end
`ifdef AM_PSUM_SATURATE_EN
    exp_ovf_sum = ACC_MAX;
`else
    exp_ovf_sum = 64'd2730284;
`endif
    drive(0, 0, 0, 1);
    chk_out("ovf", 1, 1, exp_ovf_sum, 1);
    tick();

    // Reset in the middle of a window clears outputs immediately.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1000 + i, 9, 1);
      tick();
    end
    drive(0, 0, 0, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid.out_sum", longint'(out_sum), 0);
    chk("rst_mid.out_ovf", longint'(out_ovf), 0);
    chk("rst_mid.out_valid", longint'(out_valid), 0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    drive(1, 5, 1, 1); tick();
    drive(1, 6, 1, 1); tick();
    drive(0, 0, 0, 1);
    chk_out("rst_after", 1, 1, 11, 0);
    tick();

    // Bubbles between beats; cfg_len change after the first beat is ignored.
    drive(1, 10, 2, 1); tick();
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 3; i++) begin
        drive(0, 16'hFFFF, 0, 1);
        chk_out("bubble.gap", 1, 0, 0, 0);
        tick();
      end
      drive(1, (g == 0) ? 20 : 30, 0, 1);
      tick();
    end
    drive(0, 0, 0, 1);
    chk_out("bubble.result", 1, 1, 60, 0);
    tick();
    chk_out("bubble.single", 1, 0, 0, 0);
    tick();

    // Randomized stream against a window-level model.
    in_win = 1'b0;
    rem    = 0;
    run    = 0;
    for (int c = 0; c < 3000; c++) begin
      bit          v;
      bit          r;
      bit          e_ir;
      bit          e_ov;
      int unsigned p;
      int unsigned l;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      p = ($urandom_range(0, 7) == 0) ? 65025 : $urandom_range(0, 65535);
      l = ($urandom_range(0, 15) == 0) ? 300 : $urandom_range(0, 7);
      drive(v, p, l, r);
      e_ov = (q.size() != 0);
      e_ir = !e_ov || r;
      chk_out("rand", e_ir, e_ov, e_ov ? q[0].sum : 0, e_ov ? q[0].ovf : 1'b0);
      if (e_ov && r) void'(q.pop_front());
      if (v && e_ir) begin
        if (!in_win) begin
          in_win = 1'b1;
          rem    = int'(l) + 1;
          run    = 0;
        end
        run += longint'(p);
        rem--;
        if (rem == 0) begin
          res_t rr;
`ifdef AM_PSUM_SATURATE_EN
          rr.sum = (run > ACC_MAX) ? ACC_MAX : run;
`else
          rr.sum = run % (ACC_MAX + 1);
`endif
          rr.ovf = (run > ACC_MAX);
          q.push_back(rr);
          in_win = 1'b0;
        end
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
